// File: rtl/cpu_core.sv
// cpu_core: 16-bit-instruction, multi-cycle accumulator-free load/store core.
// Sequencing is FETCH -> EXEC -> (MEM) -> FETCH, with HALT as a terminal state
// that only reset leaves.
//
// Ports
//   clock, reset            : single clock, synchronous active-high reset
//   imem_req/imem_addr      : instruction fetch request, address = PC
//   imem_valid/imem_rdata   : fetch completion and instruction word
//   dmem_req/dmem_we        : data access request, 1 = store / 0 = load
//   dmem_addr/dmem_wdata    : zero-extended a8 and store data R[rd]
//   dmem_valid/dmem_rdata   : access completion and load data
//   retired                 : one-cycle pulse per completed instruction
//   halted                  : high while in HALT
module cpu_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_valid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retired,
  output logic              halted
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_ADDI = 4'h2, OP_AND  = 4'h3,
    OP_ANDI = 4'h4, OP_LD   = 4'h5, OP_ST   = 4'h6, OP_CMP  = 4'h7,
    OP_JMP  = 4'h8, OP_JZ   = 4'h9, OP_JNZ  = 4'hA, OP_JC   = 4'hB,
    OP_JNC  = 4'hC, OP_RSVD = 4'hD, OP_RSVE = 4'hE, OP_HALT = 4'hF
  } op_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [16];
  logic              zf;
  logic              cf;
  logic [15:0]       instr;

  op_t               op;
  logic [3:0]        rd;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_val;
  logic [DATA_W-1:0] alu_val;
  logic              wr_en;
  logic              taken;
  logic              is_mem;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_jmp;

  // Decode and execute from the latched instruction.
  always_comb begin
    op      = op_t'(instr[15:12]);
    rd      = instr[11:8];
    rs_val  = regs[instr[7:4]];
    rt_val  = regs[instr[3:0]];
    // Signed size casts sign-extend imm4 / off12 (off12 truncates when ADDR_W < 12).
    imm_val = DATA_W'($signed(instr[3:0]));
    pc_inc  = pc + ADDR_W'(1);
    pc_jmp  = pc + ADDR_W'($signed(instr[11:0]));
    is_mem  = (op == OP_LD) || (op == OP_ST);
    alu_val = '0;
    wr_en   = 1'b0;
    taken   = 1'b0;
    case (op)
      OP_ADD:  begin alu_val = rs_val + rt_val;  wr_en = 1'b1; end
      OP_ADDI: begin alu_val = rs_val + imm_val; wr_en = 1'b1; end
      OP_AND:  begin alu_val = rs_val & rt_val;  wr_en = 1'b1; end
      OP_ANDI: begin alu_val = rs_val & imm_val; wr_en = 1'b1; end
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = zf;
      OP_JNZ:  taken = ~zf;
      OP_JC:   taken = cf;
      OP_JNC:  taken = ~cf;
      default: ;
    endcase
  end

  // Handshake outputs follow the state directly so that a zero-wait response
  // completes in the request cycle; reset forces them low.
  always_comb begin
    imem_req   = !reset && (state == FETCH);
    imem_addr  = pc;
    dmem_req   = !reset && (state == MEM);
    dmem_we    = (op == OP_ST);
    dmem_addr  = ADDR_W'(instr[7:0]);
    dmem_wdata = regs[rd];
    halted     = !reset && (state == HALT);
    retired    = !reset && (((state == EXEC) && !is_mem) ||
                            ((state == MEM) && dmem_valid));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc    <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
      instr <= '0;
      for (int unsigned i = 0; i < 16; i++) regs[i[3:0]] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            instr <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op == OP_HALT) begin
            state <= HALT;
          end else if (is_mem) begin
            state <= MEM;
          end else begin
            if (wr_en) regs[rd] <= alu_val;
            if (op == OP_CMP) begin
              zf <= (rs_val == rt_val);
              cf <= (rs_val < rt_val);
            end
            pc    <= taken ? pc_jmp : pc_inc;
            state <= FETCH;
          end
        end
        MEM: begin
          if (dmem_valid) begin
            if (op == OP_LD) regs[rd] <= dmem_rdata;
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed programs against cpu_core with a wait-state memory
// responder; expected values are hand-computed from the instruction set.
module tb_cpu_core;
  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [11:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_valid;
  logic [15:0] dmem_rdata;
  logic        retired;
  logic        halted;

  cpu_core #(.DATA_W(16), .ADDR_W(12)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_valid (dmem_valid),
    .dmem_rdata (dmem_rdata),
    .retired    (retired),
    .halted     (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] held;
    logic [31:0] stable;
  } acc_t;

  logic [15:0] imem [4096];
  logic [15:0] dmem [256];
  logic [31:0] fetch_q [$];
  logic [31:0] exp_q [$];
  acc_t        acc_q [$];
  acc_t        cur;

  int n_checks = 0;
  int n_errors = 0;
  int ilat = 0, dlat = 0, iw = 0, dw = 0;
  int cyc = 0, ret_cnt = 0, both_cnt = 0;
  bit noise = 0;

  logic [31:0] o_ireq, o_iaddr, o_dreq, o_dwe, o_daddr, o_dwdata, o_ret, o_halt;

  int t2_exp  [9] = '{0, 1, 2, 9, 10, 14, 15, 17, 18};
  int t2b_exp [6] = '{0, 1, 2, 9, 10, 11};
  int t4_exp  [4] = '{0, 'hFFF, 0, 'hFFF};
  int t3_we   [5] = '{1, 0, 1, 1, 1};
  int t3_addr [5] = '{'h20, 'h20, 'h21, 'h22, 'h23};
  int t3_data [5] = '{'hFFFA, 0, 'hFFFA, 'hFFFA, 'hFFF4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample outputs at the falling edge, answer requests,
  // then re-sample retired since it depends on the data-side response.
  task automatic cycle();
    @(negedge clock);
    o_ireq   = 32'(imem_req);
    o_iaddr  = 32'(imem_addr);
    o_dreq   = 32'(dmem_req);
    o_dwe    = 32'(dmem_we);
    o_daddr  = 32'(dmem_addr);
    o_dwdata = 32'(dmem_wdata);
    o_halt   = 32'(halted);
    cyc++;
    if (o_ireq[0] && o_dreq[0]) both_cnt++;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    if (noise) begin
      imem_valid = cyc[0];
      dmem_valid = ~cyc[0];
      imem_rdata = 16'($urandom);
      dmem_rdata = 16'($urandom);
    end else begin
      if (o_ireq[0]) begin
        if (iw >= ilat) begin
          imem_valid = 1'b1;
          imem_rdata = imem[o_iaddr[11:0]];
          fetch_q.push_back(o_iaddr);
          iw = 0;
        end else iw++;
      end else iw = 0;
      if (o_dreq[0]) begin
        if (dw == 0) begin
          cur.we = o_dwe; cur.addr = o_daddr; cur.data = o_dwdata; cur.stable = 1;
        end else if (o_dwe !== cur.we || o_daddr !== cur.addr || o_dwdata !== cur.data) begin
          cur.stable = 0;
        end
        dw++;
        if (dw > dlat) begin
          dmem_valid = 1'b1;
          if (o_dwe[0]) dmem[o_daddr[7:0]] = o_dwdata[15:0];
          else dmem_rdata = dmem[o_daddr[7:0]];
          cur.held = dw;
          acc_q.push_back(cur);
          dw = 0;
        end
      end else dw = 0;
    end
    #1;
    o_ret = 32'(retired);
    if (o_ret[0]) ret_cnt++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) imem[i] = 16'hF000;
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    fetch_q.delete();
    acc_q.delete();
    ret_cnt = 0;
    cyc = 0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cycle();
    check(tag, {28'd0, o_ireq[0], o_dreq[0], o_ret[0], o_halt[0]}, 0);
    release_reset();
  endtask

  task automatic run_to_halt(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (o_halt !== 32'd1 && n < maxc);
    check(tag, o_halt, 1);
  endtask

  task automatic check_fetch(input string tag);
    check({tag, "_count"}, 32'(fetch_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < fetch_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), fetch_q[i], exp_q[i]);
  endtask

  initial begin
    logic [12:0] ret_vec;
    int bad, fq, aq;
    reset = 1'b1;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    imem_rdata = '0;
    dmem_rdata = '0;

    // ADDI/ADDI/ADD then store of r3; retire cycle pattern
    clear_mem();
    imem[0] = 16'h2105; imem[1] = 16'h220D; imem[2] = 16'h1312; imem[3] = 16'h6320;
    ilat = 0; dlat = 0;
    do_reset("t1_reset_outputs");
    ret_vec = '0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      ret_vec[c] = o_ret[0];
      if (c == 1) begin
        check("t1_first_req", o_ireq, 1);
        check("t1_first_addr", o_iaddr, 0);
      end
      if (c == 9) begin
        check("t1_st_req", o_dreq, 1);
        check("t1_st_we", o_dwe, 1);
        check("t1_st_addr", o_daddr, 'h20);
        check("t1_r3_value", o_dwdata, 2);
      end
    end
    check("t1_retire_cycles", 32'(ret_vec), 32'h0A54);
    check("t1_halted", o_halt, 1);

    // CMP then JC taken, JZ/JNC not taken, JNZ taken; one fetch wait state
    clear_mem();
    imem[0] = 16'h2102; imem[1] = 16'h2205; imem[2] = 16'h8007;
    imem[9] = 16'h7012; imem[10] = 16'hB004; imem[14] = 16'h9005;
    imem[15] = 16'hA002; imem[17] = 16'hC003;
    ilat = 1; dlat = 0;
    do_reset("t2_reset_outputs");
    run_to_halt("t2_halt", 200);
    exp_q.delete();
    foreach (t2_exp[i]) exp_q.push_back(t2_exp[i]);
    check_fetch("t2_fetch");
    check("t2_retired", ret_cnt, 9);

    // Same point with JZ: not taken, falls through to 11
    imem[10] = 16'h9004;
    do_reset("t2b_reset_outputs");
    run_to_halt("t2b_halt", 200);
    exp_q.delete();
    foreach (t2b_exp[i]) exp_q.push_back(t2b_exp[i]);
    check_fetch("t2b_fetch");

    // ANDI/AND/ADD wrap and store/load with three data wait states
    clear_mem();
    imem[0] = 16'h230E; imem[1] = 16'h433B; imem[2] = 16'h6320; imem[3] = 16'h5420;
    imem[4] = 16'h6421; imem[5] = 16'h3534; imem[6] = 16'h6522; imem[7] = 16'h1633;
    imem[8] = 16'h6623;
    ilat = 0; dlat = 3;
    do_reset("t3_reset_outputs");
    run_to_halt("t3_halt", 300);
    check("t3_acc_count", 32'(acc_q.size()), 5);
    for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
      check($sformatf("t3_we_%0d", i), acc_q[i].we, t3_we[i]);
      check($sformatf("t3_addr_%0d", i), acc_q[i].addr, t3_addr[i]);
      check($sformatf("t3_held_%0d", i), acc_q[i].held, 4);
      check($sformatf("t3_stable_%0d", i), acc_q[i].stable, 1);
      if (t3_we[i] == 1) check($sformatf("t3_data_%0d", i), acc_q[i].data, t3_data[i]);
    end

    // JMP -1 at PC 0 wraps to 0xFFF; NOP at 0xFFF wraps PC to 0
    clear_mem();
    imem[0] = 16'h8FFF; imem[4095] = 16'h0000;
    ilat = 0; dlat = 0;
    do_reset("t4_reset_outputs");
    repeat (8) cycle();
    exp_q.delete();
    foreach (t4_exp[i]) exp_q.push_back(t4_exp[i]);
    check_fetch("t4_fetch");

    // Reset in the second wait cycle of a load abandons it
    clear_mem();
    imem[0] = 16'h6431; imem[1] = 16'h5430; imem[2] = 16'h6432;
    dmem[8'h30] = 16'h1234;
    ilat = 0; dlat = 5;
    do_reset("t5_reset_outputs");
    for (int c = 1; c <= 12; c++) cycle();
    check("t5_in_load_req", o_dreq, 1);
    check("t5_in_load_we", o_dwe, 0);
    reset = 1'b1;
    cycle();
    check("t5_reset_mid_load_outputs", {28'd0, o_ireq[0], o_dreq[0], o_ret[0], o_halt[0]}, 0);
    check("t5_retired_before", ret_cnt, 1);
    release_reset();
    dlat = 0;
    cycle();
    check("t5_restart_req", o_ireq, 1);
    check("t5_restart_addr", o_iaddr, 0);
    run_to_halt("t5_halt", 100);
    check("t5_acc_count", 32'(acc_q.size()), 3);
    if (acc_q.size() == 3) begin
      check("t5_st_data", acc_q[0].data, 0);
      check("t5_ld_addr", acc_q[1].addr, 'h30);
      check("t5_ld_result", acc_q[2].data, 'h1234);
    end
    check("t5_retired_after", ret_cnt, 4);

    // HALT ignores valid toggling; reset restarts fetching at 0
    fq = fetch_q.size();
    aq = acc_q.size();
    bad = 0;
    noise = 1;
    repeat (10) begin
      cycle();
      if (o_ireq !== 0 || o_dreq !== 0 || o_halt !== 1 || o_ret !== 0) bad++;
    end
    noise = 0;
    cycle();
    check("t6_bad_halt_cycles", bad, 0);
    check("t6_still_halted", o_halt, 1);
    check("t6_no_new_fetch", 32'(fetch_q.size()), 32'(fq));
    check("t6_no_new_access", 32'(acc_q.size()), 32'(aq));
    do_reset("t6_reset_outputs");
    cycle();
    check("t6_restart_req", o_ireq, 1);
    check("t6_restart_addr", o_iaddr, 0);
    check("t6_not_halted", o_halt, 0);

    check("both_requests_never", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter DATA_W, default 16: register, ALU and data-memory word width; legal range 8 to 32.
REQ-002 Parameter ADDR_W, default 12: PC and memory address width; legal range 8 to 16.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  ADDR_W  fetch address; equals PC.
REQ-007 imem_valid  input  1  imem_rdata valid; completes the fetch.
REQ-008 imem_rdata  input  16  instruction word.
REQ-009 dmem_req  output  1  data access request.
REQ-010 dmem_we  output  1  1 = store, 0 = load; valid while dmem_req is high.
REQ-011 dmem_addr  output  ADDR_W  zero-extended instr[7:0].
REQ-012 dmem_wdata  output  DATA_W  store data, R[instr[11:8]].
REQ-013 dmem_valid  input  1  access complete; dmem_rdata is valid for loads.
REQ-014 dmem_rdata  input  DATA_W  load data.
REQ-015 retired  output  1  one-cycle pulse per completed instruction.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 Instruction fields: op=[15:12], rd=[11:8], rs=[7:4], rt/imm4=[3:0], a8=[7:0], off12=[11:0].
REQ-018 Internal state: 16 registers of DATA_W bits, PC of ADDR_W bits, flags ZF and CF.
REQ-019 Opcodes 0 NOP; 1 ADD rd=rs+rt; 2 ADDI rd=rs+sext(imm4); 3 AND rd=rs&rt; 4 ANDI rd=rs&sext(imm4); 5 LD rd=M[a8]; 6 ST M[a8]=rd; 7 CMP rs,rt; 8 JMP; 9 JZ; A JNZ; B JC; C JNC; F HALT; D and E execute as NOP.
REQ-020 Arithmetic: ADD/ADDI wrap modulo 2^DATA_W; carry-out is discarded; ADD/AND never change flags.
REQ-021 CMP: ZF=(rs==rt), CF=(rs<rt unsigned); CMP is the only instruction that writes the flags.
REQ-022 Jumps: when taken, PC = PC + sext(off12) modulo 2^ADDR_W; otherwise PC = PC + 1, wrapping from all-ones to 0.
REQ-023 Branch conditions: JZ when ZF=1, JNZ when ZF=0, JC when CF=1, JNC when CF=0; JMP is always taken.
REQ-024 FSM states: FETCH, EXEC, MEM, HALT.
REQ-025 FETCH: imem_req=1 and imem_addr=PC; hold until imem_valid=1, latch the instruction, go to EXEC.
REQ-026 imem_valid may be high in the first request cycle (zero wait state); each cycle imem_valid=0 adds one stall cycle.
REQ-027 EXEC, for NOP/ALU/CMP/jumps: write back or update flags, update PC, pulse retired, go to FETCH.
REQ-028 EXEC, for LD/ST: go to MEM.
REQ-029 EXEC, for HALT: go to HALT; PC is not changed and retired pulses.
REQ-030 MEM: dmem_req=1 with dmem_we, dmem_addr and dmem_wdata held stable until dmem_valid=1.
REQ-031 MEM completion (dmem_valid=1): LD writes dmem_rdata to rd; PC+1; retired pulses; go to FETCH.
REQ-032 Latency with zero wait states: 2 cycles for non-memory instructions, 3 cycles for LD/ST.
REQ-033 imem_req and dmem_req are never high in the same cycle.
REQ-034 imem_valid outside FETCH and dmem_valid outside MEM are ignored.
REQ-035 HALT: all requests stay low, halted=1; the core leaves HALT only on reset.

Reset
REQ-036 On a rising edge with reset=1: state=FETCH, PC=0, all registers=0, ZF=CF=0, latched instruction = NOP.
REQ-037 While reset=1: imem_req, dmem_req, retired and halted are all 0.
REQ-038 Reset during a stall in FETCH or MEM abandons the access: no register write, no flag write, no retire.
REQ-039 Fetch from address 0 begins in the first cycle after reset deasserts.

Verification
REQ-040 Program ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2, zero-wait memory -> r3=2, retired pulses in cycles 2, 4 and 6.
REQ-041 CMP r1,r2 with r1=2, r2=5 then JC +4 at PC=10 -> ZF=0, CF=1, next imem_addr=14; JZ at the same point -> not taken, next imem_addr=11.
REQ-042 ST r3,0x20 then LD r4,0x20, with dmem_valid delayed 3 cycles -> dmem_req held 4 cycles per access with stable address and data; r4=r3.
REQ-043 JMP -1 at PC=0 -> next imem_addr=0xFFF for ADDR_W=12; at PC=0xFFF a non-jump instruction -> next PC=0.
REQ-044 Reset asserted in the second wait cycle of an LD -> rd unchanged, retired stays 0, first cycle after release imem_addr=0.
REQ-045 HALT, then toggle imem_valid and dmem_valid for 10 cycles -> halted=1, no requests, no state change; reset then returns the core to fetching from address 0.
